time_syn_tx: RTL and testbench

//  Builds and sends time-sync control frames on the ctrl TX AXIS link. Counterpart of the ctrl RX time-sync parser.

---
 rtl/time_syn_tx.sv | 179 +++++++++++++++++
 tb/tb_time_syn_tx.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_syn_tx.sv
// Time-sync control frame transmitter: queues timestamp, standard-time and return-timestamp
// requests one-deep per type and sends each as a two-beat AXIS frame (preamble, payload).
module time_syn_tx #(
   parameter logic [7:0]  P_TS_PRE     = 8'h66,
   parameter logic [7:0]  P_STD_PRE    = 8'h88,
   parameter logic [7:0]  P_RETURN_PRE = 8'h55,
   parameter logic [63:0] P_TS_COMP    = 64'd0
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [63:0] i_local_time,
   input  logic        i_ts_req,
   input  logic        i_std_req,
   input  logic [63:0] i_std_time,
   input  logic        i_return_req,
   input  logic [63:0] i_return_ts,
   output logic        o_tx_busy,
   output logic        o_req_drop,
   output logic        m_ctrl_tx_axis_tvalid,
   output logic [63:0] m_ctrl_tx_axis_tdata,
   output logic        m_ctrl_tx_axis_tlast,
   output logic [7:0]  m_ctrl_tx_axis_tkeep,
   output logic        m_ctrl_tx_axis_tuser,
   input  logic        m_ctrl_tx_axis_tready
);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_PRE = 2'd1, ST_PAY = 2'd2} state_t;
   typedef enum logic [1:0] {SEL_TS = 2'd0, SEL_STD = 2'd1, SEL_RET = 2'd2} sel_t;

   state_t      state_r, state_nxt_s;
   sel_t        sel_r, sel_nxt_s;
   logic [63:0] hold_r, hold_nxt_s;
   logic        ts_pend_r, std_pend_r, ret_pend_r;
   logic        ts_pend_nxt_s, std_pend_nxt_s, ret_pend_nxt_s;
   logic [63:0] std_data_r, ret_data_r, std_data_nxt_s, ret_data_nxt_s;
   logic        tvalid_r, tvalid_nxt_s, tlast_r, tlast_nxt_s;
   logic [63:0] tdata_r, tdata_nxt_s;
   logic [7:0]  tkeep_r;
   logic        busy_r, drop_r, drop_nxt_s;
   logic        grant_en_s, gnt_ts_s, gnt_std_s, gnt_ret_s;

   // Frame sequencing, arbitration and next beat contents
   always_comb begin
      state_nxt_s  = state_r;
      sel_nxt_s    = sel_r;
      hold_nxt_s   = hold_r;
      tvalid_nxt_s = tvalid_r;
      tdata_nxt_s  = tdata_r;
      tlast_nxt_s  = tlast_r;
      grant_en_s   = 1'b0;
      gnt_ts_s     = 1'b0;
      gnt_std_s    = 1'b0;
      gnt_ret_s    = 1'b0;
      case (state_r)
         ST_IDLE: grant_en_s = 1'b1;
         ST_PRE: begin
            if (m_ctrl_tx_axis_tready) begin
               state_nxt_s = ST_PAY;
               tlast_nxt_s = 1'b1;
               if (sel_r == SEL_TS) begin
                  tdata_nxt_s = i_local_time + P_TS_COMP;
               end else begin
                  tdata_nxt_s = hold_r;
               end
            end else begin
               state_nxt_s = ST_PRE;
            end
         end
         ST_PAY: begin
            if (m_ctrl_tx_axis_tready) begin
               grant_en_s = 1'b1;
            end else begin
               state_nxt_s = ST_PAY;
            end
         end
         default: begin
            state_nxt_s  = ST_IDLE;
            tvalid_nxt_s = 1'b0;
            tdata_nxt_s  = 64'd0;
            tlast_nxt_s  = 1'b0;
         end
      endcase
      // Fixed priority return > ts > std; an empty queue returns to idle
      if (grant_en_s) begin
         state_nxt_s  = ST_PRE;
         tvalid_nxt_s = 1'b1;
         tlast_nxt_s  = 1'b0;
         if (ret_pend_r) begin
            gnt_ret_s   = 1'b1;
            sel_nxt_s   = SEL_RET;
            hold_nxt_s  = ret_data_r;
            tdata_nxt_s = {56'd0, P_RETURN_PRE};
         end else if (ts_pend_r) begin
            gnt_ts_s    = 1'b1;
            sel_nxt_s   = SEL_TS;
            hold_nxt_s  = 64'd0;
            tdata_nxt_s = {56'd0, P_TS_PRE};
         end else if (std_pend_r) begin
            gnt_std_s   = 1'b1;
            sel_nxt_s   = SEL_STD;
            hold_nxt_s  = std_data_r;
            tdata_nxt_s = {56'd0, P_STD_PRE};
         end else begin
            state_nxt_s  = ST_IDLE;
            tvalid_nxt_s = 1'b0;
            tdata_nxt_s  = 64'd0;
         end
      end else begin
         gnt_ret_s = 1'b0;
      end
   end

   assign ts_pend_nxt_s  = i_ts_req     | (ts_pend_r  & ~gnt_ts_s);
   assign std_pend_nxt_s = i_std_req    | (std_pend_r & ~gnt_std_s);
   assign ret_pend_nxt_s = i_return_req | (ret_pend_r & ~gnt_ret_s);
   assign drop_nxt_s     = (i_ts_req     & ts_pend_r  & ~gnt_ts_s)  |
                           (i_std_req    & std_pend_r & ~gnt_std_s) |
                           (i_return_req & ret_pend_r & ~gnt_ret_s);

   // Payload latches: the latest request wins
   always_comb begin
      std_data_nxt_s = std_data_r;
      ret_data_nxt_s = ret_data_r;
      if (i_std_req) begin
         std_data_nxt_s = i_std_time;
      end else begin
         std_data_nxt_s = std_data_r;
      end
      if (i_return_req) begin
         ret_data_nxt_s = i_return_ts;
      end else begin
         ret_data_nxt_s = ret_data_r;
      end
   end

   // State, queue and registered output update
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_r    <= ST_IDLE;
         sel_r      <= SEL_TS;
         hold_r     <= 64'd0;
         ts_pend_r  <= 1'b0;
         std_pend_r <= 1'b0;
         ret_pend_r <= 1'b0;
         std_data_r <= 64'd0;
         ret_data_r <= 64'd0;
         tvalid_r   <= 1'b0;
         tdata_r    <= 64'd0;
         tlast_r    <= 1'b0;
         tkeep_r    <= 8'h00;
         busy_r     <= 1'b0;
         drop_r     <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         sel_r      <= sel_nxt_s;
         hold_r     <= hold_nxt_s;
         ts_pend_r  <= ts_pend_nxt_s;
         std_pend_r <= std_pend_nxt_s;
         ret_pend_r <= ret_pend_nxt_s;
         std_data_r <= std_data_nxt_s;
         ret_data_r <= ret_data_nxt_s;
         tvalid_r   <= tvalid_nxt_s;
         tdata_r    <= tdata_nxt_s;
         tlast_r    <= tlast_nxt_s;
         tkeep_r    <= tvalid_nxt_s ? 8'hFF : 8'h00;
         busy_r     <= (state_nxt_s != ST_IDLE) | ts_pend_nxt_s | std_pend_nxt_s | ret_pend_nxt_s;
         drop_r     <= drop_nxt_s;
      end
   end

   assign o_tx_busy             = busy_r;
   assign o_req_drop            = drop_r;
   assign m_ctrl_tx_axis_tvalid = tvalid_r;
   assign m_ctrl_tx_axis_tdata  = tdata_r;
   assign m_ctrl_tx_axis_tlast  = tlast_r;
   assign m_ctrl_tx_axis_tkeep  = tkeep_r;
   assign m_ctrl_tx_axis_tuser  = 1'b0;

endmodule

// File: tb/tb_time_syn_tx.sv
// Self-checking bench for time_syn_tx: a beat-queue model of the frame stream is compared with
// the DUT every cycle, alongside directed scenarios with hand-computed expectations.
module tb_time_syn_tx;

   localparam logic [63:0] TS_COMP = 64'd10;

   logic        clk;
   logic        rst_n;
   logic [63:0] local_time;
   logic        ts_req, std_req, return_req;
   logic [63:0] std_time, return_ts;
   logic        tx_busy, req_drop;
   logic        tvalid, tlast, tuser, tready;
   logic [63:0] tdata;
   logic [7:0]  tkeep;

   int n_chk  = 0;
   int n_fail = 0;

   time_syn_tx #(.P_TS_COMP(TS_COMP)) dut (
      .i_clk                 (clk),
      .i_rst                 (rst_n),
      .i_local_time          (local_time),
      .i_ts_req              (ts_req),
      .i_std_req             (std_req),
      .i_std_time            (std_time),
      .i_return_req          (return_req),
      .i_return_ts           (return_ts),
      .o_tx_busy             (tx_busy),
      .o_req_drop            (req_drop),
      .m_ctrl_tx_axis_tvalid (tvalid),
      .m_ctrl_tx_axis_tdata  (tdata),
      .m_ctrl_tx_axis_tlast  (tlast),
      .m_ctrl_tx_axis_tkeep  (tkeep),
      .m_ctrl_tx_axis_tuser  (tuser),
      .m_ctrl_tx_axis_tready (tready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: the beats still to be sent, plus one pending slot per type (0=return,1=ts,2=std)
   typedef struct packed {logic [63:0] d; logic last;} beat_t;
   beat_t       q[$];
   bit          pend [3];
   logic [63:0] pdata [3];
   logic [63:0] held;
   int          cur;
   bit          m_drop, m_busy;

   function automatic logic [7:0] pre_byte(input int i);
      case (i)
         0:       return 8'h55;
         1:       return 8'h66;
         default: return 8'h88;
      endcase
   endfunction

   task automatic model_step();
      beat_t b;
      bit g [3];
      bit rq [3];
      logic [63:0] rd [3];
      bit granted;
      rq = '{return_req, ts_req, std_req};
      rd = '{return_ts, 64'd0, std_time};
      g = '{1'b0, 1'b0, 1'b0};
      if (q.size() != 0 && tready) begin
         b = q.pop_front();
         if (!b.last) begin
            b.d    = (cur == 1) ? local_time + TS_COMP : held;
            b.last = 1'b1;
            q.push_back(b);
         end
      end
      if (q.size() == 0) begin
         granted = 1'b0;
         for (int i = 0; i < 3; i++) begin
            if (pend[i] && !granted) begin
               granted = 1'b1;
               g[i]    = 1'b1;
               cur     = i;
               held    = pdata[i];
               b.d     = {56'd0, pre_byte(i)};
               b.last  = 1'b0;
               q.push_back(b);
            end
         end
      end
      m_drop = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (rq[i]) begin
            if (pend[i] && !g[i]) m_drop = 1'b1;
            pend[i]  = 1'b1;
            pdata[i] = rd[i];
         end else if (g[i]) begin
            pend[i] = 1'b0;
         end
      end
      m_busy = (q.size() != 0) || pend[0] || pend[1] || pend[2];
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         pend   = '{1'b0, 1'b0, 1'b0};
         pdata  = '{64'd0, 64'd0, 64'd0};
         held   = 64'd0;
         cur    = 0;
         m_drop = 1'b0;
         m_busy = 1'b0;
      end else begin
         model_step();
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      logic ev;
      ev = (q.size() != 0);
      check("tvalid", 64'(tvalid), 64'(ev));
      check("tdata", tdata, ev ? q[0].d : 64'd0);
      check("tlast", 64'(tlast), ev ? 64'(q[0].last) : 64'd0);
      check("tkeep", 64'(tkeep), ev ? 64'hFF : 64'h00);
      check("tuser", 64'(tuser), 64'd0);
      check("busy", 64'(tx_busy), 64'(m_busy));
      check("drop", 64'(req_drop), 64'(m_drop));
   end

   task automatic tick();
      @(negedge clk);
      local_time = local_time + 64'd1;
   endtask

   task automatic idle(input int n);
      ts_req = 1'b0; std_req = 1'b0; return_req = 1'b0; tready = 1'b1;
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      logic [63:0] t0;
      logic [63:0] exp3 [6];
      logic [63:0] last_pay;
      int drops;
      rst_n = 1'b0; local_time = 64'd1000; tready = 1'b1;
      ts_req = 1'b0; std_req = 1'b0; return_req = 1'b0;
      std_time = 64'd0; return_ts = 64'd0;
      tick(); tick();
      rst_n = 1'b1;
      tick();
      check("reset_tvalid", 64'(tvalid), 64'd0);
      check("reset_busy", 64'(tx_busy), 64'd0);

      // 1: return frame latency
      return_req = 1'b1; return_ts = 64'h1234;
      tick();
      return_req = 1'b0;
      check("t1_n1_tvalid", 64'(tvalid), 64'd0);
      tick();
      check("t1_beat0", tdata, 64'h55);
      check("t1_beat0_valid", 64'(tvalid), 64'd1);
      tick();
      check("t1_beat1", tdata, 64'h1234);
      check("t1_beat1_last", 64'(tlast), 64'd1);
      tick();
      check("t1_after", 64'(tvalid), 64'd0);
      idle(3);

      // 2: timestamp payload = time at preamble acceptance + compensation
      t0 = local_time; ts_req = 1'b1;
      tick();
      ts_req = 1'b0;
      tick();
      check("t2_beat0", tdata, 64'h66);
      tick();
      check("t2_beat1", tdata, t0 + 64'd12);
      idle(3);

      // 3: all three at once, back-to-back frames
      t0 = local_time;
      return_req = 1'b1; return_ts = 64'hAAAA_0001;
      ts_req = 1'b1;
      std_req = 1'b1; std_time = 64'hBBBB_0002;
      tick();
      return_req = 1'b0; ts_req = 1'b0; std_req = 1'b0;
      exp3 = '{64'h55, 64'hAAAA_0001, 64'h66, t0 + 64'd14, 64'h88, 64'hBBBB_0002};
      for (int k = 0; k < 6; k++) begin
         tick();
         check("t3_valid", 64'(tvalid), 64'd1);
         check("t3_data", tdata, exp3[k]);
      end
      idle(3);

      // 4: stalls during preamble and payload
      return_req = 1'b1; return_ts = 64'h77;
      tick();
      return_req = 1'b0;
      tick();
      tready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         check("t4_pre_hold", tdata, 64'h55);
         check("t4_pre_last", 64'(tlast), 64'd0);
      end
      tready = 1'b1;
      tick();
      tready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         check("t4_pay_hold", tdata, 64'h77);
         check("t4_pay_last", 64'(tlast), 64'd1);
      end
      tready = 1'b1;
      tick();
      check("t4_done", 64'(tvalid), 64'd0);
      idle(3);

      // 5: overwrite of a pending std request
      drops = 0; last_pay = 64'd0;
      std_req = 1'b1; std_time = 64'h1;
      tick();
      std_req = 1'b0;
      tick();
      tick();
      tready = 1'b0;
      std_req = 1'b1; std_time = 64'hA;
      tick();
      std_time = 64'hB;
      tick();
      std_req = 1'b0;
      for (int k = 0; k < 8; k++) begin
         if (k == 3) tready = 1'b1;
         drops += int'(req_drop);
         if (tvalid && tlast) last_pay = tdata;
         tick();
      end
      check("t5_drops", 64'(drops), 64'd1);
      check("t5_payload", last_pay, 64'hB);
      idle(3);

      // 6: reset in the middle of a payload beat
      return_req = 1'b1; return_ts = 64'h99;
      tick();
      return_req = 1'b0;
      tick();
      tick();
      tready = 1'b0;
      std_req = 1'b1;
      tick();
      std_req = 1'b0;
      #2 rst_n = 1'b0;
      #1 check("t6_tvalid_now", 64'(tvalid), 64'd0);
      tick();
      rst_n = 1'b1; tready = 1'b1;
      tick();
      check("t6_busy", 64'(tx_busy), 64'd0);
      check("t6_tvalid", 64'(tvalid), 64'd0);
      idle(3);

      // Randomised traffic against the model
      for (int k = 0; k < 3000; k++) begin
         return_req = ($urandom_range(0, 7) == 0);
         ts_req     = ($urandom_range(0, 7) == 0);
         std_req    = ($urandom_range(0, 7) == 0);
         return_ts  = {$urandom, $urandom};
         std_time   = {$urandom, $urandom};
         tready     = ($urandom_range(0, 3) != 0);
         tick();
      end
      idle(12);
      check("final_idle", 64'(tx_busy), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
